// File: rtl/cgol_chk_pkg.sv
// cgol_chk_pkg: shared state encoding and vector record for the cgol vector checker
package cgol_chk_pkg;
  localparam int DEF_ROW_W = 8;
  localparam int DEF_COL_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t;
  typedef struct packed {
    logic [DEF_ROW_W-1:0] row;
    logic [DEF_COL_W-1:0] col;
  } cgol_vec_t;
endpackage

// File: rtl/cgol_vec_mem.sv
// cgol_vec_mem: expected-vector table, one synchronous write port, one combinational read port, no reset
module cgol_vec_mem #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int W = 17
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // table write; contents survive reset so a run can be repeated without reloading
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/cgol_vector_checker.sv
// cgol_vector_checker: compares observed cgol {row,col} vectors against a loaded table and reports status
module cgol_vector_checker
  import cgol_chk_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int ROW_W = 8,
  parameter int COL_W = 8,
  parameter int DEPTH = 256,
  parameter int RST_W = 4,
  parameter int ERR_W = 16,
  parameter bit STOP_ON_ERR = 1'b0,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int EW = 1 + NUM_CH * (ROW_W + COL_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RST_W-1:0]        dut_rst_lines,
  input  logic                    load_en,
  input  logic [AW-1:0]           load_addr,
  input  logic [EW-1:0]           load_data,
  input  logic                    start,
  input  logic                    obs_valid,
  input  logic [NUM_CH*ROW_W-1:0] obs_row,
  input  logic [NUM_CH*COL_W-1:0] obs_col,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    mismatch,
  output logic [NUM_CH-1:0]       err_ch,
  output logic [ERR_W-1:0]        err_count,
  output logic [AW:0]             vec_count,
  output logic [AW-1:0]           first_err_idx,
  output logic                    first_err_vld
);
  localparam int SW = ROW_W + COL_W;
  localparam int VW = AW + 1;
  chk_state_t state, nxt;
  logic [AW-1:0] idx;
  logic [EW-1:0] entry;
  logic [NUM_CH-1:0] ch_err;
  logic vld, cmp, bad, launch;
  cgol_vec_mem #(.DEPTH(DEPTH), .AW(AW), .W(EW)) u_mem (
    .clk   (clk),
    .we    (load_en && state != RUN),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (idx),
    .rdata (entry)
  );
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_err[c] = entry[c*SW+COL_W +: ROW_W] != obs_row[c*ROW_W +: ROW_W] ||
                       entry[c*SW +: COL_W] != obs_col[c*COL_W +: COL_W];
  end
  assign vld = entry[EW-1];
  assign bad = |ch_err;
  assign cmp = state == RUN && vld && obs_valid && !(|dut_rst_lines);
  assign launch = state != RUN && start;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  // state register; reset aborts any run but leaves the table alone
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // next state: end marker is checked before any compare, then last index or stop-on-error
  always_comb begin
    nxt = state;
    if (state != RUN) nxt = start ? RUN : state;
    else if (!vld || (cmp && (idx == AW'(DEPTH - 1) || (STOP_ON_ERR && bad)))) nxt = DONE;
  end
  // run counters and registered compare results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      mismatch <= 1'b0;
      err_ch <= '0;
      err_count <= '0;
      vec_count <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      mismatch <= cmp && bad;
      if (launch) begin
        idx <= '0;
        err_ch <= '0;
        err_count <= '0;
        vec_count <= '0;
        first_err_idx <= '0;
        first_err_vld <= 1'b0;
      end else if (cmp) begin
        idx <= idx + AW'(1);
        vec_count <= vec_count + VW'(1);
        err_ch <= ch_err;
        if (bad) begin
          err_count <= &err_count ? err_count : err_count + ERR_W'(1);
          first_err_idx <= first_err_vld ? first_err_idx : idx;
          first_err_vld <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cgol_vector_checker.sv
// tb_cgol_vector_checker: scenario tasks checked against a table-walking reference model
module tb_cgol_vector_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_rst_lines = '0;
  logic        a_load_en = 1'b0, a_start = 1'b0, a_obs_valid = 1'b0;
  logic [2:0]  a_load_addr = '0;
  logic [32:0] a_load_data = '0;
  logic [15:0] a_obs_row = '0, a_obs_col = '0;
  logic        a_busy, a_done, a_pass, a_mismatch, a_first_err_vld;
  logic [1:0]  a_err_ch, a_err_count;
  logic [3:0]  a_vec_count;
  logic [2:0]  a_first_err_idx;

  logic [3:0]  b_rst_lines = '0;
  logic        b_load_en = 1'b0, b_start = 1'b0, b_obs_valid = 1'b0;
  logic [1:0]  b_load_addr = '0;
  logic [16:0] b_load_data = '0;
  logic [7:0]  b_obs_row = '0, b_obs_col = '0;
  logic        b_busy, b_done, b_pass, b_mismatch, b_first_err_vld;
  logic [0:0]  b_err_ch;
  logic [15:0] b_err_count;
  logic [2:0]  b_vec_count;
  logic [1:0]  b_first_err_idx;

  cgol_vector_checker #(.NUM_CH(2), .ROW_W(8), .COL_W(8), .DEPTH(8), .RST_W(4), .ERR_W(2), .STOP_ON_ERR(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .dut_rst_lines(a_rst_lines), .load_en(a_load_en), .load_addr(a_load_addr),
    .load_data(a_load_data), .start(a_start), .obs_valid(a_obs_valid), .obs_row(a_obs_row), .obs_col(a_obs_col),
    .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch(a_mismatch), .err_ch(a_err_ch), .err_count(a_err_count),
    .vec_count(a_vec_count), .first_err_idx(a_first_err_idx), .first_err_vld(a_first_err_vld));

  cgol_vector_checker #(.NUM_CH(1), .ROW_W(8), .COL_W(8), .DEPTH(4), .RST_W(4), .ERR_W(16), .STOP_ON_ERR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .dut_rst_lines(b_rst_lines), .load_en(b_load_en), .load_addr(b_load_addr),
    .load_data(b_load_data), .start(b_start), .obs_valid(b_obs_valid), .obs_row(b_obs_row), .obs_col(b_obs_col),
    .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch(b_mismatch), .err_ch(b_err_ch), .err_count(b_err_count),
    .vec_count(b_vec_count), .first_err_idx(b_first_err_idx), .first_err_vld(b_first_err_vld));

  int checks = 0, failures = 0;
  logic [7:0] m_row [2][8], m_col [2][8], o_row [2][8], o_col [2][8];
  logic m_vld [8];
  int stall_n [8], stall_k [8];
  bit poke = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stalls;
    for (int i = 0; i < 8; i++) begin
      stall_n[i] = 0;
      stall_k[i] = 1;
    end
  endtask

  task automatic set_t1;
    for (int i = 0; i < 8; i++) begin
      m_vld[i] = i < 4;
      m_row[0][i] = 8'(2 * i + 1);
      m_col[0][i] = 8'(2 * i + 2);
      m_row[1][i] = 8'(8'h10 + i);
      m_col[1][i] = 8'(8'h20 + i);
      for (int c = 0; c < 2; c++) begin
        o_row[c][i] = m_row[c][i];
        o_col[c][i] = m_col[c][i];
      end
    end
    clear_stalls();
  endtask

  task automatic load_a;
    for (int i = 0; i < 8; i++) begin
      a_load_en = 1'b1;
      a_load_addr = 3'(i);
      a_load_data = {m_vld[i], m_row[1][i], m_col[1][i], m_row[0][i], m_col[0][i]};
      tick();
    end
    a_load_en = 1'b0;
  endtask

  task automatic do_run(input string nm);
    int len, errs, first, wait_n;
    logic [1:0] ce, last_ce;
    len = 0;
    while (len < 8 && m_vld[len]) len++;
    errs = 0;
    first = -1;
    last_ce = '0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      for (int s = 0; s < stall_n[k]; s++) begin
        a_obs_valid = stall_k[k] == 2;
        a_rst_lines = stall_k[k] == 2 ? (k == 1 ? 4'b0100 : 4'($urandom_range(1, 15))) : 4'b0000;
        a_obs_row = 16'($urandom);
        a_obs_col = 16'($urandom);
        tick();
        checks++;
        if (a_vec_count !== 4'(k)) begin
          failures++;
          $display("FAIL %s holdoff k=%0d vec_count got %0d want %0d", nm, k, a_vec_count, k);
        end
      end
      a_rst_lines = '0;
      a_obs_valid = 1'b1;
      a_obs_row = {o_row[1][k], o_row[0][k]};
      a_obs_col = {o_col[1][k], o_col[0][k]};
      if (poke && k == 0) begin
        a_load_en = 1'b1;
        a_load_addr = '0;
        a_load_data = '1;
      end
      tick();
      a_load_en = 1'b0;
      for (int c = 0; c < 2; c++) ce[c] = o_row[c][k] != m_row[c][k] || o_col[c][k] != m_col[c][k];
      if (ce != 0) begin
        errs++;
        if (first < 0) first = k;
      end
      last_ce = ce;
      checks++;
      if (a_mismatch !== (ce != 0) || a_err_ch !== ce || a_vec_count !== 4'(k + 1)) begin
        failures++;
        $display("FAIL %s compare k=%0d mismatch/err_ch/vec_count got %0b/%0b/%0d want %0b/%0b/%0d",
                 nm, k, a_mismatch, a_err_ch, a_vec_count, ce != 0, ce, k + 1);
      end
    end
    a_obs_valid = 1'b0;
    wait_n = 0;
    while (!a_done && wait_n < 5) begin
      tick();
      wait_n++;
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end done/busy got %0b/%0b want 1/0", nm, a_done, a_busy);
    end
    checks++;
    if (a_vec_count !== 4'(len) || a_err_count !== 2'(errs > 3 ? 3 : errs)) begin
      failures++;
      $display("FAIL %s counts vec/err got %0d/%0d want %0d/%0d", nm, a_vec_count, a_err_count, len, errs > 3 ? 3 : errs);
    end
    checks++;
    if (a_first_err_vld !== (first >= 0) || (first >= 0 && a_first_err_idx !== 3'(first))) begin
      failures++;
      $display("FAIL %s first_err vld/idx got %0b/%0d want %0b/%0d", nm, a_first_err_vld, a_first_err_idx, first >= 0, first);
    end
    checks++;
    if (a_pass !== (errs == 0) || a_err_ch !== last_ce) begin
      failures++;
      $display("FAIL %s pass/err_ch got %0b/%0b want %0b/%0b", nm, a_pass, a_err_ch, errs == 0, last_ce);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_busy, a_done, a_pass, a_mismatch, a_err_ch, a_err_count, a_vec_count, a_first_err_idx, a_first_err_vld} !== '0 ||
        {b_busy, b_done, b_pass, b_mismatch, b_err_ch, b_err_count, b_vec_count, b_first_err_idx, b_first_err_vld} !== '0) begin
      failures++;
      $display("FAIL reset outputs nonzero a_busy=%0b a_done=%0b b_busy=%0b b_done=%0b", a_busy, a_done, b_busy, b_done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_match;
    set_t1();
    load_a();
    do_run("t1_match");
  endtask

  task automatic test_mismatch;
    set_t1();
    o_row[0][2] = 8'd5;
    o_col[0][2] = 8'd7;
    do_run("t2_mismatch");
  endtask

  task automatic test_holdoff;
    set_t1();
    stall_n[1] = 3;
    stall_k[1] = 2;
    stall_n[3] = 2;
    stall_k[3] = 1;
    do_run("t3_holdoff");
  endtask

  task automatic test_empty;
    set_t1();
    m_vld[0] = 1'b0;
    load_a();
    do_run("empty_entry0");
  endtask

  task automatic test_reset_midrun;
    set_t1();
    load_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_obs_valid = 1'b1;
      a_obs_row = {o_row[1][k], o_row[0][k]};
      a_obs_col = {o_col[1][k], o_col[0][k]};
      tick();
    end
    a_obs_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({a_busy, a_done, a_pass, a_mismatch, a_err_ch, a_err_count, a_vec_count, a_first_err_idx, a_first_err_vld} !== '0) begin
      failures++;
      $display("FAIL t5_reset outputs busy=%0b done=%0b vec_count=%0d want all 0", a_busy, a_done, a_vec_count);
    end
    rst_n = 1'b1;
    do_run("t5_rerun");
  endtask

  task automatic test_saturate;
    set_t1();
    for (int i = 0; i < 8; i++) m_vld[i] = i < 5;
    load_a();
    for (int i = 0; i < 5; i++) o_row[1][i] = m_row[1][i] + 8'd1;
    poke = 1;
    do_run("t6_sat");
    poke = 0;
    for (int i = 0; i < 5; i++) o_row[1][i] = m_row[1][i];
    do_run("t6_table_kept");
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int len;
      len = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) begin
        m_vld[i] = i < len;
        for (int c = 0; c < 2; c++) begin
          m_row[c][i] = 8'($urandom_range(0, 255));
          m_col[c][i] = 8'($urandom_range(0, 255));
          o_row[c][i] = m_row[c][i];
          o_col[c][i] = m_col[c][i];
        end
        if ($urandom_range(0, 2) == 0) begin
          int c;
          c = $urandom_range(0, 1);
          if ($urandom_range(0, 1) == 0) o_row[c][i] ^= 8'(1 << $urandom_range(0, 7));
          else o_col[c][i] ^= 8'(1 << $urandom_range(0, 7));
        end
        stall_n[i] = $urandom_range(0, 2);
        stall_k[i] = $urandom_range(1, 2);
      end
      load_a();
      do_run("random");
    end
  endtask

  task automatic b_load_t1;
    for (int i = 0; i < 4; i++) begin
      b_load_en = 1'b1;
      b_load_addr = 2'(i);
      b_load_data = {1'b1, 8'(2 * i + 1), 8'(2 * i + 2)};
      tick();
    end
    b_load_en = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic test_depth_end;
    b_load_t1();
    for (int k = 0; k < 4; k++) begin
      b_obs_valid = 1'b1;
      b_obs_row = 8'(2 * k + 1);
      b_obs_col = 8'(2 * k + 2);
      tick();
    end
    checks++;
    if (b_done !== 1'b1 || b_vec_count !== 3'd4 || b_pass !== 1'b1 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL t4_depth done/vec/pass got %0b/%0d/%0b want 1/4/1", b_done, b_vec_count, b_pass);
    end
    b_obs_row = 8'd1;
    b_obs_col = 8'd2;
    tick();
    b_obs_valid = 1'b0;
    checks++;
    if (b_vec_count !== 3'd4 || b_done !== 1'b1) begin
      failures++;
      $display("FAIL t4_nowrap vec_count got %0d want 4", b_vec_count);
    end
  endtask

  task automatic test_stop_on_err;
    b_load_t1();
    for (int k = 0; k < 3; k++) begin
      b_obs_valid = 1'b1;
      b_obs_row = 8'(2 * k + 1);
      b_obs_col = k == 2 ? 8'd7 : 8'(2 * k + 2);
      tick();
    end
    checks++;
    if (b_mismatch !== 1'b1 || b_done !== 1'b1 || b_vec_count !== 3'd3 || b_err_ch !== 1'b1) begin
      failures++;
      $display("FAIL t2_stop mismatch/done/vec/err_ch got %0b/%0b/%0d/%0b want 1/1/3/1", b_mismatch, b_done, b_vec_count, b_err_ch);
    end
    checks++;
    if (b_first_err_vld !== 1'b1 || b_first_err_idx !== 2'd2 || b_err_count !== 16'd1 || b_pass !== 1'b0) begin
      failures++;
      $display("FAIL t2_stop first/idx/err/pass got %0b/%0d/%0d/%0b want 1/2/1/0", b_first_err_vld, b_first_err_idx, b_err_count, b_pass);
    end
    b_obs_col = 8'd8;
    tick();
    b_obs_valid = 1'b0;
    checks++;
    if (b_vec_count !== 3'd3 || b_mismatch !== 1'b0) begin
      failures++;
      $display("FAIL t2_stop_idle vec/mismatch got %0d/%0b want 3/0", b_vec_count, b_mismatch);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_holdoff();
    test_reset_midrun();
    test_saturate();
    test_empty();
    test_depth_end();
    test_stop_on_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
